// File: rtl/spi_mem_pkg.sv
// Shared encodings for the SPI memory slave: FSM states, R/W bit values and
// shift-register operating modes.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCmd   = 3'd1,
    StFetch = 3'd2,
    StData  = 3'd3,
    StWrite = 3'd4,
    StHold  = 3'd5
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ShHold  = 2'd0,
    ShLeft  = 2'd1,
    ShPload = 2'd2
  } shift_mode_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// MSB-first shift register with hold, shift-left and parallel-load modes.
module spi_shift_reg
  import spi_mem_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   mode,
  input  logic         sin,
  input  logic [W-1:0] pin,
  output logic [W-1:0] pout,
  output logic         sout
);

  logic [W-1:0] data_q;

  // Register update selected by mode; unknown codes hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      case (mode)
        ShLeft:  data_q <= {data_q[W-2:0], sin};
        ShPload: data_q <= pin;
        default: data_q <= data_q;
      endcase
    end
  end

  assign pout = data_q;
  assign sout = data_q[W-1];

endmodule

// File: rtl/spi_mem_burst_ctrl.sv
// SPI mode-0 slave control for a small memory: command frame (address, R/W bit)
// followed by one or more data words, with optional burst auto-increment.
module spi_mem_burst_ctrl
  import spi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned BURST_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              sclk_rise,
  input  logic              sclk_fall,
  input  logic              mosi,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_rd,
  output logic              miso,
  output logic              miso_oe,
  output logic              busy
);

  localparam int unsigned MaxBits = max_u(ADDR_W + 1, DATA_W);
  localparam int unsigned CntW    = $clog2(MaxBits + 1);
  // The final bit of each frame/word is taken straight from mosi, so the
  // receive register only needs to hold the bits before it.
  localparam int unsigned RxW     = max_u(ADDR_W, DATA_W - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              oe_q, oe_d;
  logic              skip_q, skip_d;

  logic [1:0]        rx_mode, tx_mode;
  logic [RxW-1:0]    rx_word;
  logic              rx_sout;
  logic [DATA_W-1:0] tx_word;
  logic              tx_sout;

  spi_shift_reg #(
    .W (RxW)
  ) u_rx (
    .clk   (clk),
    .reset (reset),
    .mode  (rx_mode),
    .sin   (mosi),
    .pin   ({RxW{1'b0}}),
    .pout  (rx_word),
    .sout  (rx_sout)
  );

  // MISO is the transmit MSB: it moves only on a parallel load or a shift.
  spi_shift_reg #(
    .W (DATA_W)
  ) u_tx (
    .clk   (clk),
    .reset (reset),
    .mode  (tx_mode),
    .sin   (1'b0),
    .pin   (mem_rdata),
    .pout  (tx_word),
    .sout  (tx_sout)
  );

  logic unused_bits;
  assign unused_bits = ^{tx_word, rx_sout};

  // Next-state and datapath control for the frame sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    oe_d    = oe_q;
    skip_d  = skip_q;
    rx_mode = ShHold;
    tx_mode = ShHold;

    if (state_q != StIdle && cs) begin
      // Deselect aborts everything, including a coincident sclk edge.
      state_d = StIdle;
      oe_d    = 1'b0;
      skip_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!cs) begin
            state_d = StCmd;
            cnt_d   = '0;
          end
        end

        StCmd: begin
          if (sclk_rise) begin
            rx_mode = ShLeft;
            if (cnt_q == CntW'(ADDR_W)) begin
              addr_d  = rx_word[ADDR_W-1:0];
              rw_d    = mosi;
              cnt_d   = '0;
              state_d = (mosi == RW_READ) ? StFetch : StData;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
        end

        StFetch: begin
          // The loaded MSB is already on MISO, so the next fall must not shift.
          tx_mode = ShPload;
          oe_d    = 1'b1;
          skip_d  = 1'b1;
          state_d = StData;
        end

        StData: begin
          if (rw_q == RW_WRITE) begin
            if (sclk_rise) begin
              rx_mode = ShLeft;
              if (cnt_q == CntW'(DATA_W - 1)) begin
                wdata_d = {rx_word[DATA_W-2:0], mosi};
                cnt_d   = '0;
                state_d = StWrite;
              end else begin
                cnt_d = cnt_q + CntW'(1);
              end
            end
          end else begin
            if (sclk_rise) begin
              if (cnt_q == CntW'(DATA_W - 1)) begin
                cnt_d = '0;
                if (BURST_EN != 0) begin
                  addr_d  = addr_q + ADDR_W'(1);
                  state_d = StFetch;
                end else begin
                  oe_d    = 1'b0;
                  state_d = StHold;
                end
              end else begin
                cnt_d = cnt_q + CntW'(1);
              end
            end else if (sclk_fall) begin
              if (skip_q) begin
                skip_d = 1'b0;
              end else begin
                tx_mode = ShLeft;
              end
            end
          end
        end

        StWrite: begin
          cnt_d = '0;
          if (BURST_EN != 0) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = StData;
          end else begin
            state_d = StHold;
          end
        end

        StHold: begin
          oe_d = 1'b0;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rw_q    <= RW_WRITE;
      addr_q  <= '0;
      wdata_q <= '0;
      oe_q    <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      oe_q    <= oe_d;
      skip_q  <= skip_d;
    end
  end

  // Strobes decode from state so a reset removes them immediately.
  assign mem_we    = (state_q == StWrite);
  assign mem_rd    = (state_q == StFetch);
  assign busy      = (state_q != StIdle);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign miso      = tx_sout;
  assign miso_oe   = oe_q;

endmodule
